// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_ctrl
//  Function : HI/LO register pair with a small controller that waits for a
//             multiplier or divider result, captures it, and flags
//             divide-by-zero and timeout conditions. HI/LO can also be
//             written directly (mthi/mtlo) while idle.
//  Revision : 1.0 - initial release
// ============================================================================
module hilo_ctrl #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic             mult_done,
   input  logic [WIDTH-1:0] mult_hi,
   input  logic [WIDTH-1:0] mult_lo,
   input  logic             div_done,
   input  logic [WIDTH-1:0] div_rem,
   input  logic [WIDTH-1:0] div_quo,
   input  logic             div_by_zero,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             ready,
   output logic             err_div0,
   output logic             err_timeout
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_MULT = 2'd1,
      WAIT_DIV  = 2'd2
   } state_t;

   // Count value present on the cycle whose edge would take the wait
   // counter to TIMEOUT-1; a missing done on that edge is a timeout.
   localparam logic [15:0] c_cnt_last = 16'(TIMEOUT - 2);

   state_t             r_state;
   logic [15:0]        r_cnt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_ready;
   logic               r_err_div0;
   logic               r_err_timeout;
   logic               w_expire;

   // Wait budget exhausted on this edge unless the matching done shows up.
   assign w_expire = (r_cnt == c_cnt_last);

   // Controller state, wait counter, HI/LO and status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_hi          <= '0;
         r_lo          <= '0;
         r_ready       <= 1'b0;
         r_err_div0    <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (mult_start) begin
                  r_state       <= WAIT_MULT;
                  r_cnt         <= '0;
                  r_err_div0    <= 1'b0;
                  r_err_timeout <= 1'b0;
               end else if (div_start) begin
                  r_state       <= WAIT_DIV;
                  r_cnt         <= '0;
                  r_err_div0    <= 1'b0;
                  r_err_timeout <= 1'b0;
               end else begin
                  if (mthi) r_hi <= wdata;
                  if (mtlo) r_lo <= wdata;
               end
            end
            WAIT_MULT: begin
               if (mult_done) begin
                  r_hi    <= mult_hi;
                  r_lo    <= mult_lo;
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
                  if (w_expire) begin
                     r_err_timeout <= 1'b1;
                     r_state       <= IDLE;
                  end
               end
            end
            WAIT_DIV: begin
               if (div_done) begin
                  // A zero divisor invalidates the result: keep HI/LO.
                  if (div_by_zero) begin
                     r_err_div0 <= 1'b1;
                  end else begin
                     r_hi    <= div_rem;
                     r_lo    <= div_quo;
                     r_ready <= 1'b1;
                  end
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
                  if (w_expire) begin
                     r_err_timeout <= 1'b1;
                     r_state       <= IDLE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign hi          = r_hi;
   assign lo          = r_lo;
   assign busy        = (r_state != IDLE);
   assign ready       = r_ready;
   assign err_div0    = r_err_div0;
   assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of HI, LO and all operand/result buses.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum number of wait cycles for a mult/div result; legal range 2..65535.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port mult_start  input  1  one-cycle request to await a multiplier result.
REQ-006 SHALL have port div_start  input  1  one-cycle request to await a divider result.
REQ-007 SHALL have port mult_done  input  1  multiplier result valid on mult_hi/mult_lo.
REQ-008 SHALL have ports mult_hi and mult_lo  input  WIDTH each  multiplier upper and lower product.
REQ-009 SHALL have port div_done  input  1  divider result valid on div_rem/div_quo.
REQ-010 SHALL have ports div_rem and div_quo  input  WIDTH each  divider remainder (to HI) and quotient (to LO).
REQ-011 SHALL have port div_by_zero  input  1  qualifies div_done; the result is invalid.
REQ-012 SHALL have ports mthi and mtlo  input  1 each  direct-write strobes for HI and LO.
REQ-013 SHALL have port wdata  input  WIDTH  data for mthi/mtlo.
REQ-014 SHALL have ports hi and lo  output  WIDTH each  registered HI/LO contents.
REQ-015 SHALL have port busy  output  1  high while waiting for a mult/div result.
REQ-016 SHALL have port ready  output  1  one-cycle pulse after a successful HI/LO capture from mult/div.
REQ-017 SHALL have ports err_div0 and err_timeout  output  1 each  sticky error flags.

Function
REQ-018 SHALL implement the FSM states IDLE, WAIT_MULT and WAIT_DIV; busy = (state != IDLE).
REQ-019 In IDLE, mult_start SHALL move the FSM to WAIT_MULT; div_start SHALL move it to WAIT_DIV; if both are high in the same cycle, mult_start SHALL win and div_start SHALL be dropped.
REQ-020 An accepted start SHALL clear err_div0 and err_timeout, and SHALL clear the wait counter to 0.
REQ-021 When not in IDLE, start inputs SHALL be ignored.
REQ-022 In WAIT_MULT, mult_done SHALL load hi<=mult_hi and lo<=mult_lo at that edge and return the FSM to IDLE; ready SHALL be high for exactly the following cycle.
REQ-023 In WAIT_DIV, div_done with div_by_zero=0 SHALL load hi<=div_rem and lo<=div_quo, return the FSM to IDLE and pulse ready.
REQ-024 In WAIT_DIV, div_done with div_by_zero=1 SHALL leave hi/lo unchanged, set err_div0, return the FSM to IDLE and not pulse ready.
REQ-025 In WAIT_MULT, div_done SHALL be ignored; in WAIT_DIV, mult_done SHALL be ignored; in IDLE, both done inputs SHALL be ignored.
REQ-026 The wait counter SHALL increment once per cycle in a WAIT state without the matching done; when it reaches TIMEOUT-1 without done, the block SHALL set err_timeout, return to IDLE and leave hi/lo unchanged.
REQ-027 If the matching done arrives in the same cycle the counter reaches TIMEOUT-1, done SHALL take priority and no timeout occurs.
REQ-028 In IDLE with no start, mthi SHALL load hi<=wdata and mtlo SHALL load lo<=wdata; if both are high, both SHALL load wdata.
REQ-029 If mthi/mtlo is high in the same cycle as an accepted start, the start SHALL win and the move SHALL be dropped; mthi/mtlo SHALL be ignored while busy.
REQ-030 hi and lo SHALL be driven directly from registers, with no combinational path from the inputs to any output.

Reset
REQ-031 Asserting reset_n=0 SHALL immediately force state=IDLE, hi=0, lo=0, busy=0, ready=0, err_div0=0, err_timeout=0 and counter=0, independent of clk.
REQ-032 A reset asserted during WAIT_MULT or WAIT_DIV SHALL discard the pending operation; a done arriving after reset is released SHALL be ignored.

Verification
REQ-033 The bench SHALL cover: mult_start; 5 cycles later mult_done with mult_hi=32'h1, mult_lo=32'hFFFF_0000 -> hi/lo take these values at that edge, ready high for 1 cycle, busy low.
REQ-034 The bench SHALL cover: div_start, then div_done with div_by_zero=1 and div_rem=7, div_quo=9, with prior hi=lo=32'hA5 -> hi/lo remain 32'hA5, err_div0=1, ready stays 0; a subsequent mult_start clears err_div0.
REQ-035 The bench SHALL cover: TIMEOUT=4, div_start with no done -> after 3 WAIT cycles err_timeout=1 and the FSM is back in IDLE; a later div_done is ignored.
REQ-036 The bench SHALL cover: mult_start, div_start and mthi all high in the same IDLE cycle -> FSM enters WAIT_MULT, hi is unchanged, and div_done then has no effect.
REQ-037 The bench SHALL cover: mthi and mtlo together with wdata=32'hDEAD_BEEF in IDLE -> hi=lo=32'hDEAD_BEEF next edge; mtlo while busy -> lo is unchanged.
REQ-038 The bench SHALL cover: reset_n pulsed low mid-WAIT_DIV, between clock edges -> all outputs are 0 immediately; a div_done after release is ignored.
